// File: rtl/alu_control_unit.sv
// ALU control decoder: maps ALUop and the R-type function field to a registered
// 3-bit ALU operation select, and flags combinations that cannot be decoded.
module alu_control_unit (
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] alu_ctr,
   input  logic [5:0] function_code,
   input  logic [2:0] ALUop,
   output logic       illegal
);

   // ALU operation encodings
   localparam logic [2:0] CtrAnd = 3'b000;
   localparam logic [2:0] CtrOr  = 3'b001;
   localparam logic [2:0] CtrAdd = 3'b010;
   localparam logic [2:0] CtrSub = 3'b110;
   localparam logic [2:0] CtrSlt = 3'b111;

   // ALUop classes from main control
   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpAnd   = 3'b100;
   localparam logic [2:0] OpOr    = 3'b101;
   localparam logic [2:0] OpSlt   = 3'b110;
   localparam logic [2:0] OpRType = 3'b111;

   // R-type function field values (all six bits compared)
   localparam logic [5:0] FnAdd = 6'b000010;
   localparam logic [5:0] FnSub = 6'b000011;
   localparam logic [5:0] FnAnd = 6'b000100;
   localparam logic [5:0] FnOr  = 6'b000101;
   localparam logic [5:0] FnSlt = 6'b000111;

   logic [2:0] alu_ctr_d;
   logic       illegal_d;

   // Decode the current inputs; undecodable combinations fall back to add
   always_comb begin
      alu_ctr_d = CtrAdd;
      illegal_d = 1'b0;
      case (ALUop)
         OpAdd:   alu_ctr_d = CtrAdd;
         OpSub:   alu_ctr_d = CtrSub;
         OpAnd:   alu_ctr_d = CtrAnd;
         OpOr:    alu_ctr_d = CtrOr;
         OpSlt:   alu_ctr_d = CtrSlt;
         OpRType: begin
            case (function_code)
               FnAdd:   alu_ctr_d = CtrAdd;
               FnSub:   alu_ctr_d = CtrSub;
               FnAnd:   alu_ctr_d = CtrAnd;
               FnOr:    alu_ctr_d = CtrOr;
               FnSlt:   alu_ctr_d = CtrSlt;
               default: begin
                  alu_ctr_d = CtrAdd;
                  illegal_d = 1'b1;
               end
            endcase
         end
         default: begin
            alu_ctr_d = CtrAdd;
            illegal_d = 1'b1;
         end
      endcase
   end

   // Register the decode; reset overrides whatever is on the inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_ctr <= CtrAdd;
         illegal <= 1'b0;
      end else begin
         alu_ctr <= alu_ctr_d;
         illegal <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_control_unit.sv
// Testbench for alu_control_unit: directed vector table, hand-written timing
// sequences, and random stimulus checked against a lookup-table model.
module tb_alu_control_unit;

   logic       clk;
   logic       reset;
   logic [2:0] alu_ctr;
   logic [5:0] function_code;
   logic [2:0] ALUop;
   logic       illegal;

   int tests;
   int failures;

   alu_control_unit dut (
      .clk           (clk),
      .reset         (reset),
      .alu_ctr       (alu_ctr),
      .function_code (function_code),
      .ALUop         (ALUop),
      .illegal       (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic [2:0] op;
      logic [5:0] fc;
      logic [2:0] exp_ctr;
      logic       exp_ill;
   } vec_t;

   // Reference tables: I-type result per ALUop, R-type result per function code
   logic [2:0] itype_ctr [8];
   logic       itype_ok  [8];
   logic [2:0] rtype_ctr [64];
   logic       rtype_ok  [64];

   task automatic build_model();
      for (int i = 0; i < 8; i++) begin
         itype_ok[i]  = 1'b0;
         itype_ctr[i] = 3'b010;
      end
      for (int i = 0; i < 64; i++) begin
         rtype_ok[i]  = 1'b0;
         rtype_ctr[i] = 3'b010;
      end
      itype_ctr[0] = 3'b010; itype_ok[0] = 1'b1;
      itype_ctr[1] = 3'b110; itype_ok[1] = 1'b1;
      itype_ctr[4] = 3'b000; itype_ok[4] = 1'b1;
      itype_ctr[5] = 3'b001; itype_ok[5] = 1'b1;
      itype_ctr[6] = 3'b111; itype_ok[6] = 1'b1;
      rtype_ctr[2] = 3'b010; rtype_ok[2] = 1'b1;
      rtype_ctr[3] = 3'b110; rtype_ok[3] = 1'b1;
      rtype_ctr[4] = 3'b000; rtype_ok[4] = 1'b1;
      rtype_ctr[5] = 3'b001; rtype_ok[5] = 1'b1;
      rtype_ctr[7] = 3'b111; rtype_ok[7] = 1'b1;
   endtask

   function automatic void model(input logic rst, input logic [2:0] op, input logic [5:0] fc,
                                 output logic [2:0] ctr, output logic ill);
      if (rst) begin
         ctr = 3'b010;
         ill = 1'b0;
      end else if (op == 3'b111) begin
         ctr = rtype_ctr[fc];
         ill = !rtype_ok[fc];
      end else begin
         ctr = itype_ctr[op];
         ill = !itype_ok[op];
      end
   endfunction

   task automatic check(input string name, input logic [2:0] exp_ctr, input logic exp_ill);
      tests++;
      if (alu_ctr !== exp_ctr || illegal !== exp_ill) begin
         failures++;
         $display("FAIL %s: got alu_ctr=%b illegal=%b, expected alu_ctr=%b illegal=%b",
                  name, alu_ctr, illegal, exp_ctr, exp_ill);
      end
   endtask

   // Drive inputs at the falling edge, then sample just after the rising edge
   task automatic apply(input logic rst, input logic [2:0] op, input logic [5:0] fc);
      @(negedge clk);
      reset         = rst;
      ALUop         = op;
      function_code = fc;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      logic [2:0] e_ctr;
      logic       e_ill;
      tests    = 0;
      failures = 0;
      reset         = 1'b1;
      ALUop         = 3'b000;
      function_code = 6'b000000;
      build_model();

      vecs.push_back('{"reset_hold",   1'b1, 3'b001, 6'b000000, 3'b010, 1'b0});
      vecs.push_back('{"reset_release",1'b0, 3'b001, 6'b000000, 3'b110, 1'b0});
      vecs.push_back('{"i_add",        1'b0, 3'b000, 6'b000010, 3'b010, 1'b0});
      vecs.push_back('{"i_sub",        1'b0, 3'b001, 6'b000011, 3'b110, 1'b0});
      vecs.push_back('{"i_and",        1'b0, 3'b100, 6'b000100, 3'b000, 1'b0});
      vecs.push_back('{"i_or",         1'b0, 3'b101, 6'b000101, 3'b001, 1'b0});
      vecs.push_back('{"i_slt",        1'b0, 3'b110, 6'b000111, 3'b111, 1'b0});
      vecs.push_back('{"r_add",        1'b0, 3'b111, 6'b000010, 3'b010, 1'b0});
      vecs.push_back('{"r_sub",        1'b0, 3'b111, 6'b000011, 3'b110, 1'b0});
      vecs.push_back('{"r_and",        1'b0, 3'b111, 6'b000100, 3'b000, 1'b0});
      vecs.push_back('{"r_or",         1'b0, 3'b111, 6'b000101, 3'b001, 1'b0});
      vecs.push_back('{"r_slt",        1'b0, 3'b111, 6'b000111, 3'b111, 1'b0});
      vecs.push_back('{"ill_op010",    1'b0, 3'b010, 6'b000011, 3'b010, 1'b1});
      vecs.push_back('{"ill_op011",    1'b0, 3'b011, 6'b000100, 3'b010, 1'b1});
      vecs.push_back('{"ill_fn000000", 1'b0, 3'b111, 6'b000000, 3'b010, 1'b1});
      vecs.push_back('{"ill_fn000110", 1'b0, 3'b111, 6'b000110, 3'b010, 1'b1});
      vecs.push_back('{"legal_after",  1'b0, 3'b111, 6'b000011, 3'b110, 1'b0});
      vecs.push_back('{"ill_fn100010", 1'b0, 3'b111, 6'b100010, 3'b010, 1'b1});
      vecs.push_back('{"ill_fn010011", 1'b0, 3'b111, 6'b010011, 3'b010, 1'b1});
      vecs.push_back('{"i_ignore_fn",  1'b0, 3'b100, 6'b111111, 3'b000, 1'b0});

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].op, vecs[i].fc);
         check(vecs[i].name, vecs[i].exp_ctr, vecs[i].exp_ill);
      end

      // Outputs must hold when inputs change mid-cycle
      apply(1'b0, 3'b101, 6'b000000);
      check("hold_before", 3'b001, 1'b0);
      #2;
      ALUop         = 3'b010;
      function_code = 6'b000111;
      #1;
      check("hold_midcycle", 3'b001, 1'b0);
      @(posedge clk);
      #1;
      check("hold_next_edge", 3'b010, 1'b1);

      // Mid-stream reset, then recovery
      apply(1'b0, 3'b111, 6'b000111);
      check("mid_decode", 3'b111, 1'b0);
      apply(1'b1, 3'b111, 6'b000111);
      check("mid_reset", 3'b010, 1'b0);
      apply(1'b0, 3'b111, 6'b000111);
      check("mid_resume", 3'b111, 1'b0);

      // Reset from an illegal state clears the flag
      apply(1'b0, 3'b011, 6'b000000);
      check("pre_reset_ill", 3'b010, 1'b1);
      apply(1'b1, 3'b011, 6'b000000);
      check("reset_clears_ill", 3'b010, 1'b0);

      // Random back-to-back stimulus, biased toward R-type with low function codes
      for (int n = 0; n < 400; n++) begin
         logic       r;
         logic [2:0] op;
         logic [5:0] fc;
         r  = ($urandom_range(0, 19) == 0);
         op = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         fc = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         apply(r, op, fc);
         model(r, op, fc, e_ctr, e_ill);
         check($sformatf("rand%0d_op%b_fn%b_r%b", n, op, fc, r), e_ctr, e_ill);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
